// File: rtl/core_dmem_resp_pkg.sv
// Shared state encodings, size codes and request record for the data-memory responder.
package core_dmem_resp_pkg;

   typedef enum logic [1:0] {
      DMEM_S_IDLE   = 2'd0,
      DMEM_S_WAIT   = 2'd1,
      DMEM_S_ACCESS = 2'd2,
      DMEM_S_RESP   = 2'd3
   } dmem_state_e;

   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;

   // Everything captured at accept; err is resolved up front so later states only act on it.
   typedef struct packed {
      logic        is_load;
      logic        err;
      logic        sign_b;
      logic        sign_h;
      logic [3:0]  strb;
      logic [1:0]  boff;
      logic [31:0] wdata;
   } dmem_req_t;

   function automatic logic strb_legal(input logic [3:0] s);
      return (s == STRB_B) || (s == STRB_H) || (s == STRB_W);
   endfunction

   function automatic logic strb_misaligned(input logic [3:0] s, input logic [1:0] boff);
      return ((s == STRB_H) && boff[0]) || ((s == STRB_W) && (boff != 2'b00));
   endfunction

endpackage

// File: rtl/core_dmem_resp_lane.sv
// Byte-lane steering: store shift/byte enables and load shift/mask/extension.
module core_dmem_lane
   import core_dmem_resp_pkg::*;
(
   input  logic [3:0]  strb,
   input  logic [1:0]  boff,
   input  logic        sign_b,
   input  logic        sign_h,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_data,
   output logic [31:0] ld_data
);

   logic [4:0]  shamt;
   logic [31:0] rshift;

   always_comb begin
      shamt   = {boff, 3'b000};
      wr_be   = strb << boff;
      wr_data = wdata << shamt;
      rshift  = rword >> shamt;
      // Only the sign flag matching the access size takes effect.
      case (strb)
         STRB_B:  ld_data = {{24{sign_b & rshift[7]}}, rshift[7:0]};
         STRB_H:  ld_data = {{16{sign_h & rshift[15]}}, rshift[15:0]};
         default: ld_data = rshift;
      endcase
   end

endmodule

// File: rtl/core_dmem_resp.sv
// Data-memory responder: accepts load/store strobes, waits, accesses a word array, pulses DONE.
module core_dmem_resp
   import core_dmem_resp_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ISLOAD_SS,
   input  logic        ISSTORE_SS,
   input  logic [31:0] DMEM_ADDR,
   input  logic [3:0]  STRB,
   input  logic        ISLOADBS,
   input  logic        ISLOADHWS,
   input  logic [31:0] WDATA,
   output logic [31:0] DMEM_RDATA,
   output logic        HCU_DMEM_BUSY,
   output logic        HCU_DMEM_DONE,
   output logic        DMEM_ERR
);

   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_e     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   dmem_req_t       req_q, req_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            mem_we;

   logic [31:0]     mem_q [MEM_WORDS];

   logic [31:0]     off;
   logic            out_of_range;
   logic            accept_err;
   logic [3:0]      wr_be;
   logic [31:0]     wr_data;
   logic [31:0]     ld_data;

   assign off          = DMEM_ADDR - BASE_ADDR;
   assign out_of_range = (DMEM_ADDR < BASE_ADDR) || ({2'b00, off[31:2]} >= MEM_WORDS);
   assign accept_err   = (ISLOAD_SS & ISSTORE_SS) | ~strb_legal(STRB)
                       | strb_misaligned(STRB, off[1:0]) | out_of_range;

   core_dmem_lane u_lane (
      .strb    (req_q.strb),
      .boff    (req_q.boff),
      .sign_b  (req_q.sign_b),
      .sign_h  (req_q.sign_h),
      .wdata   (req_q.wdata),
      .rword   (mem_q[idx_q]),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .ld_data (ld_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         DMEM_S_IDLE, DMEM_S_RESP: begin
            if (ISLOAD_SS || ISSTORE_SS) begin
               req_d = '{is_load: ISLOAD_SS, err: accept_err, sign_b: ISLOADBS,
                         sign_h: ISLOADHWS, strb: STRB, boff: off[1:0], wdata: WDATA};
               idx_d   = off[AW+1:2];
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYCLES == 0) ? DMEM_S_ACCESS : DMEM_S_WAIT;
            end else begin
               state_d = DMEM_S_IDLE;
            end
         end
         DMEM_S_WAIT: begin
            if (cnt_q == 4'd0) state_d = DMEM_S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DMEM_S_ACCESS: begin
            state_d = DMEM_S_RESP;
            done_d  = 1'b1;
            err_d   = req_q.err;
            mem_we  = !req_q.is_load && !req_q.err;
            // Errored requests of either direction report zero data.
            if (req_q.err)          rdata_d = 32'd0;
            else if (req_q.is_load) rdata_d = ld_data;
         end
         default: state_d = DMEM_S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= DMEM_S_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         idx_q   <= '0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; writes are gated by the ACCESS state, which reset leaves.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem_q[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign DMEM_RDATA    = rdata_q;
   assign HCU_DMEM_BUSY = (state_q == DMEM_S_WAIT) || (state_q == DMEM_S_ACCESS);
   assign HCU_DMEM_DONE = done_q;
   assign DMEM_ERR      = err_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// Bench for core_dmem_resp: cycle-indexed behavioural model plus directed literal checks.
module tb_core_dmem_resp;

   localparam int          W    = 2;
   localparam int          MW   = 256;
   localparam int          NC   = 8192;
   localparam logic [31:0] B    = 32'h0000_1000;
   localparam logic [3:0]  SZ_B = 4'b0001;
   localparam logic [3:0]  SZ_H = 4'b0011;
   localparam logic [3:0]  SZ_W = 4'b1111;

   logic        clk = 1'b0, rst = 1'b1;
   logic        ld = 1'b0, st = 1'b0, sb = 1'b0, sh = 1'b0;
   logic [31:0] addr = 32'd0, wd = 32'd0;
   logic [3:0]  strb = 4'b1111;
   logic [31:0] rdata, rdata0;
   logic        busy, done, err, busy0, done0, err0;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   // Model: expected outputs per cycle index, filled in when a request is accepted.
   bit          m_busy [NC];
   bit          m_done [NC];
   bit          m_err  [NC];
   bit          m_upd  [NC];
   logic [31:0] m_val  [NC];
   logic [31:0] mem_m  [MW];
   logic [31:0] cur_rdata = 32'd0;
   int          free_from = 0;
   int          pend_cyc = -1;
   int          pend_idx = 0;
   logic [31:0] pend_word = 32'd0;

   core_dmem_resp #(.MEM_WORDS(MW), .BASE_ADDR(B), .WAIT_CYCLES(W)) dut (
      .CLK(clk), .RST(rst), .ISLOAD_SS(ld), .ISSTORE_SS(st), .DMEM_ADDR(addr),
      .STRB(strb), .ISLOADBS(sb), .ISLOADHWS(sh), .WDATA(wd),
      .DMEM_RDATA(rdata), .HCU_DMEM_BUSY(busy), .HCU_DMEM_DONE(done), .DMEM_ERR(err)
   );

   core_dmem_resp #(.MEM_WORDS(MW), .BASE_ADDR(B), .WAIT_CYCLES(0)) dut0 (
      .CLK(clk), .RST(rst), .ISLOAD_SS(ld), .ISSTORE_SS(st), .DMEM_ADDR(addr),
      .STRB(strb), .ISLOADBS(sb), .ISLOADHWS(sh), .WDATA(wd),
      .DMEM_RDATA(rdata0), .HCU_DMEM_BUSY(busy0), .HCU_DMEM_DONE(done0), .DMEM_ERR(err0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every cycle, away from the active edge, the DUT must match the model.
   always @(negedge clk) begin
      if (cyc < NC) begin
         if (rst) cur_rdata = 32'd0;
         else begin
            if (cyc == pend_cyc) mem_m[pend_idx] = pend_word;
            if (m_upd[cyc]) cur_rdata = m_val[cyc];
         end
         chk("busy", {31'd0, busy}, {31'd0, m_busy[cyc]});
         chk("done", {31'd0, done}, {31'd0, m_done[cyc]});
         chk("err", {31'd0, err}, {31'd0, m_done[cyc] & m_err[cyc]});
         chk("rdata", rdata, cur_rdata);
      end
   end

   task automatic model_req(input int k, input bit l, input bit s, input logic [31:0] a,
                            input logic [3:0] sz, input bit fb, input bit fh, input logic [31:0] d);
      bit e;
      int idx, lane, r, nb;
      logic [31:0] w, v;
      if (k < free_from) return;
      r = k + W + 2;
      for (int j = k + 1; j < r; j++) m_busy[j] = 1'b1;
      e = (l && s) || !(sz == SZ_B || sz == SZ_H || sz == SZ_W)
          || (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00)
          || (a < B) || (((a - B) >> 2) >= MW);
      m_done[r] = 1'b1;
      m_err[r]  = e;
      free_from = r;
      if (e) begin
         m_upd[r] = 1'b1;
         m_val[r] = 32'd0;
         return;
      end
      idx  = int'((a - B) >> 2);
      lane = int'(a[1:0]);
      nb   = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
      w    = mem_m[idx];
      if (l) begin
         v = 32'd0;
         for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(lane+b) +: 8];
         if ((nb == 1 && fb && v[7]) || (nb == 2 && fh && v[15]))
            for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
         m_upd[r] = 1'b1;
         m_val[r] = v;
      end else begin
         for (int b = 0; b < nb; b++) w[8*(lane+b) +: 8] = d[8*b +: 8];
         pend_cyc  = k + W + 1;
         pend_idx  = idx;
         pend_word = w;
      end
   endtask

   task automatic issue(input bit l, input bit s, input logic [31:0] a, input logic [3:0] sz,
                        input bit fb, input bit fh, input logic [31:0] d);
      ld = l; st = s; addr = a; strb = sz; sb = fb; sh = fh; wd = d;
      model_req(cyc, l, s, a, sz, fb, fh, d);
      tick();
      ld = 1'b0; st = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int j = cyc; j < NC; j++) begin
         m_busy[j] = 1'b0; m_done[j] = 1'b0; m_err[j] = 1'b0; m_upd[j] = 1'b0;
      end
      pend_cyc = -1;
      repeat (n) tick();
      rst = 1'b0;
      free_from = cyc;
   endtask

   task automatic wait_done(input bit sel, output int c);
      c = -1;
      for (int i = 0; i < 40; i++) begin
         if (sel ? done0 : done) begin
            c = cyc;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL wait_done: no DONE within 40 cycles (cycle %0d)", cyc);
   endtask

   task automatic xact(input string nm, input bit l, input bit s, input logic [31:0] a,
                       input logic [3:0] sz, input bit fb, input bit fh, input logic [31:0] d,
                       input logic [31:0] er, input bit ee);
      int t, c;
      t = cyc;
      issue(l, s, a, sz, fb, fh, d);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(1'b0, c);
      chk({nm, "_lat"}, c - t, W + 2);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
      if (l || ee) chk({nm, "_rdata"}, rdata, er);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, c, c2, nd;
      do_reset(3);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      xact("sw10", 0, 1, B + 32'h10, SZ_W, 0, 0, 32'hDEADBEEF, 32'd0, 0);
      xact("lw10", 1, 0, B + 32'h10, SZ_W, 0, 0, 32'd0, 32'hDEADBEEF, 0);

      xact("sw20", 0, 1, B + 32'h20, SZ_W, 0, 0, 32'h80402010, 32'd0, 0);
      xact("lb23", 1, 0, B + 32'h23, SZ_B, 1, 0, 32'd0, 32'hFFFFFF80, 0);
      xact("lbu23", 1, 0, B + 32'h23, SZ_B, 0, 0, 32'd0, 32'h00000080, 0);
      xact("lh22", 1, 0, B + 32'h22, SZ_H, 0, 1, 32'd0, 32'hFFFF8040, 0);
      xact("lhu20", 1, 0, B + 32'h20, SZ_H, 0, 0, 32'd0, 32'h00002010, 0);
      xact("lb23_hflag", 1, 0, B + 32'h23, SZ_B, 0, 1, 32'd0, 32'h00000080, 0);
      xact("lh22_bflag", 1, 0, B + 32'h22, SZ_H, 1, 0, 32'd0, 32'h00008040, 0);

      xact("sw30", 0, 1, B + 32'h30, SZ_W, 0, 0, 32'h11223344, 32'd0, 0);
      xact("sb31", 0, 1, B + 32'h31, SZ_B, 0, 0, 32'h000000AA, 32'd0, 0);
      xact("sh32", 0, 1, B + 32'h32, SZ_H, 0, 0, 32'h0000BEEF, 32'd0, 0);
      xact("lw30", 1, 0, B + 32'h30, SZ_W, 0, 0, 32'd0, 32'hBEEFAA44, 0);

      xact("sw00", 0, 1, B, SZ_W, 0, 0, 32'h12345678, 32'd0, 0);
      xact("lw02_mis", 1, 0, B + 32'h02, SZ_W, 0, 0, 32'd0, 32'd0, 1);
      xact("sw02_mis", 0, 1, B + 32'h02, SZ_W, 0, 0, 32'hFFFFFFFF, 32'd0, 1);
      xact("lw00", 1, 0, B, SZ_W, 0, 0, 32'd0, 32'h12345678, 0);
      xact("sw10_keep", 0, 1, B + 32'h10, SZ_W, 0, 0, 32'hDEADBEEF, 32'd0, 0);
      chk("store_keeps_rdata", rdata, 32'h12345678);
      xact("lw_oor_hi", 1, 0, B + 4 * MW, SZ_W, 0, 0, 32'd0, 32'd0, 1);
      xact("lw_oor_lo", 1, 0, B - 32'd4, SZ_W, 0, 0, 32'd0, 32'd0, 1);
      xact("both", 1, 1, B + 32'h10, SZ_W, 0, 0, 32'd0, 32'd0, 1);
      xact("bad_strb", 1, 0, B + 32'h10, 4'b0111, 0, 0, 32'd0, 32'd0, 1);
      xact("lh21_mis", 1, 0, B + 32'h21, SZ_H, 0, 0, 32'd0, 32'd0, 1);

      // A strobe during WAIT must be ignored.
      issue(1, 0, B + 32'h10, SZ_W, 0, 0, 32'd0);
      issue(1, 0, B + 32'h20, SZ_W, 0, 0, 32'd0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         nd += int'(done);
         tick();
      end
      chk("wait_strobe_one_done", nd, 1);
      chk("wait_strobe_rdata", rdata, 32'hDEADBEEF);

      // A strobe in the RESP cycle starts the next request at once.
      issue(1, 0, B + 32'h20, SZ_W, 0, 0, 32'd0);
      wait_done(1'b0, c);
      issue(1, 0, B + 32'h30, SZ_W, 0, 0, 32'd0);
      wait_done(1'b0, c2);
      chk("resp_accept_lat", c2 - c, W + 2);
      chk("resp_accept_rdata", rdata, 32'hBEEFAA44);
      tick();

      // Reset during WAIT of a store aborts it.
      xact("sw40", 0, 1, B + 32'h40, SZ_W, 0, 0, 32'h00000005, 32'd0, 0);
      issue(0, 1, B + 32'h40, SZ_W, 0, 0, 32'hFFFF0000);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      do_reset(2);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         nd += int'(done);
         tick();
      end
      chk("rst_no_done", nd, 0);
      xact("lw40", 1, 0, B + 32'h40, SZ_W, 0, 0, 32'd0, 32'h00000005, 0);

      // Zero-wait-state instance.
      t = cyc;
      issue(0, 1, B + 32'h44, SZ_W, 0, 0, 32'hCAFEF00D);
      chk("w0_busy", {31'd0, busy0}, 32'd1);
      wait_done(1'b1, c);
      chk("w0_store_lat", c - t, 2);
      issue(1, 0, B + 32'h44, SZ_W, 0, 0, 32'd0);
      wait_done(1'b1, c2);
      chk("w0_b2b_lat", c2 - c, 2);
      chk("w0_rdata", rdata0, 32'hCAFEF00D);
      chk("w0_err", {31'd0, err0}, 32'd0);
      repeat (6) tick();
      t = cyc;
      issue(1, 0, B + 32'h45, SZ_H, 0, 0, 32'd0);
      wait_done(1'b1, c);
      chk("w0_err_lat", c - t, 2);
      chk("w0_err_flag", {31'd0, err0}, 32'd1);
      chk("w0_err_rdata", rdata0, 32'd0);
      repeat (6) tick();

      // Randomized traffic over a fully initialised 16-word window.
      for (int i = 0; i < 16; i++)
         xact("init", 0, 1, B + 32'(4 * i), SZ_W, 0, 0, $urandom, 32'd0, 0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [3:0]  sz;
         bit          l, s;
         int          k;
         k  = int'($urandom_range(0, 15));
         sz = (k < 5) ? SZ_B : (k < 10) ? SZ_H : (k < 14) ? SZ_W : 4'($urandom);
         a  = B + $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == SZ_W) a[1:0] = 2'b00;
            else if (sz == SZ_H) a[0] = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) a = B + 4 * MW + $urandom_range(0, 255);
         if ($urandom_range(0, 31) == 0) a = B - 32'd1 - $urandom_range(0, 15);
         l = 1'($urandom_range(0, 1));
         s = !l;
         if ($urandom_range(0, 24) == 0) begin
            l = 1'b1;
            s = 1'b1;
         end
         issue(l, s, a, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         repeat ($urandom_range(0, 6)) tick();
      end
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
